hero_write_rx: RTL and testbench

//  Receive stage for the hero write bus (test_pkg_a::hero_write_t). The bus has no backpressure.

---
 rtl/hero_write_rx.sv | 192 +++++++++++++++++++
 tb/tb_hero_write_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hero_write_rx.sv
// rtl/hero_write_rx.sv - hero write bus receive stage: beat framing, FIFO buffering, sticky errors
module hero_write_rx #(
   parameter  int DEPTH      = 8,
   parameter  int MAX_BEATS  = 16,
   parameter  int HERO_WIDTH = 36,
   localparam int BEAT_W     = $clog2(MAX_BEATS),
   localparam int LVL_W      = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [HERO_WIDTH+9:0]  hero_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [HERO_WIDTH-1:0]  out_wdat,
   output logic [6:0]             out_sub,
   output logic [BEAT_W-1:0]      out_beat_idx,
   output logic                   out_last,
   output logic [LVL_W-1:0]       fifo_level,
   output logic                   txn_done,
   output logic                   err_overflow,
   output logic                   err_length,
   output logic                   err_proto,
   input  logic                   err_clr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = HERO_WIDTH + 7 + BEAT_W + 1;

   localparam logic [1:0]        CT_VALID   = 2'd1;
   localparam logic [1:0]        CT_DONE    = 2'd2;
   localparam logic [1:0]        CT_ILLEGAL = 2'd3;
   localparam logic [LVL_W-1:0]  FULL_LVL   = LVL_W'(DEPTH);
   localparam logic [BEAT_W-1:0] LAST_IDX   = BEAT_W'(MAX_BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DROP   = 2'd2
   } state_t;

   // registered state
   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   cnt_q, cnt_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic                txn_done_q, txn_done_d;
   logic                err_overflow_q, err_overflow_d;
   logic                err_length_q, err_length_d;
   logic                err_proto_q, err_proto_d;
   logic [ENT_W-1:0]    mem_q [DEPTH];

   // decoded input beat
   logic [1:0]            cyc_type;
   logic [HERO_WIDTH-1:0] wdat_in;
   logic [6:0]            sub_in;
   logic                  clk_en_in;
   logic                  beat_qual;
   logic                  beat_is_done;
   logic                  beat_illegal;

   // FIFO control
   logic                  full;
   logic                  pop;
   logic                  push;
   logic                  wr_last;
   logic [BEAT_W-1:0]     wr_idx;
   logic [ENT_W-1:0]      wr_entry;
   logic [ENT_W-1:0]      head;
   logic                  set_ovf;
   logic                  set_len;

   // Split the bus word into its fields and classify the beat
   always_comb begin
      cyc_type     = hero_in[HERO_WIDTH+9:HERO_WIDTH+8];
      wdat_in      = hero_in[HERO_WIDTH+7:8];
      sub_in       = hero_in[7:1];
      clk_en_in    = hero_in[0];
      beat_is_done = clk_en_in && (cyc_type == CT_DONE);
      beat_qual    = clk_en_in && ((cyc_type == CT_VALID) || (cyc_type == CT_DONE));
      beat_illegal = clk_en_in && (cyc_type == CT_ILLEGAL);
   end

   // Framing FSM: decides whether the beat is written, its index and last flag
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      wr_last = 1'b0;
      wr_idx  = cnt_q;
      set_ovf = 1'b0;
      set_len = 1'b0;
      full    = (level_q == FULL_LVL);
      if (beat_qual) begin
         case (state_q)
            ST_DROP: begin
               if (beat_is_done) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               if (full) begin
                  // A full FIFO drops the beat; a VALID leaves the rest of the txn to be discarded
                  set_ovf = 1'b1;
                  cnt_d   = '0;
                  state_d = beat_is_done ? ST_IDLE : ST_DROP;
               end else begin
                  push   = 1'b1;
                  wr_idx = (state_q == ST_IDLE) ? '0 : cnt_q;
                  if (beat_is_done) begin
                     wr_last = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_IDLE;
                  end else if ((state_q == ST_ACTIVE) && (cnt_q == LAST_IDX)) begin
                     // Longest legal txn reached: close it here and swallow the remainder
                     wr_last = 1'b1;
                     set_len = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_DROP;
                  end else begin
                     cnt_d   = wr_idx + BEAT_W'(1);
                     state_d = ST_ACTIVE;
                  end
               end
            end
         endcase
      end
   end

   // FIFO pointers, occupancy and completion pulse
   always_comb begin
      pop        = (level_q != '0) && out_ready;
      wr_entry   = {wdat_in, sub_in, wr_idx, wr_last};
      head       = mem_q[rd_ptr_q];
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d    = level_q + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
      txn_done_d = push && wr_last;
   end

   // Sticky errors: a new event wins over a simultaneous clear
   always_comb begin
      err_overflow_d = set_ovf      || (err_overflow_q && !err_clr);
      err_length_d   = set_len      || (err_length_q   && !err_clr);
      err_proto_d    = beat_illegal || (err_proto_q    && !err_clr);
   end

   // Control and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         level_q        <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         txn_done_q     <= 1'b0;
         err_overflow_q <= 1'b0;
         err_length_q   <= 1'b0;
         err_proto_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         level_q        <= level_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         txn_done_q     <= txn_done_d;
         err_overflow_q <= err_overflow_d;
         err_length_q   <= err_length_d;
         err_proto_q    <= err_proto_d;
      end
   end

   // Beat storage; contents are only observed through the valid-gated head
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   // Head outputs are forced to zero while the FIFO is empty so reset clears them at once
   assign out_valid    = (level_q != '0);
   assign out_wdat     = out_valid ? head[ENT_W-1 -: HERO_WIDTH] : '0;
   assign out_sub      = out_valid ? head[BEAT_W+7:BEAT_W+1]     : '0;
   assign out_beat_idx = out_valid ? head[BEAT_W:1]              : '0;
   assign out_last     = out_valid ? head[0]                     : 1'b0;
   assign fifo_level   = level_q;
   assign txn_done     = txn_done_q;
   assign err_overflow = err_overflow_q;
   assign err_length   = err_length_q;
   assign err_proto    = err_proto_q;

endmodule

// File: tb/tb_hero_write_rx.sv
// tb/tb_hero_write_rx.sv - self-checking bench for hero_write_rx against a queue-based reference model
module tb_hero_write_rx;
   localparam int DEPTH     = 8;
   localparam int MAX_BEATS = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [45:0] hero_in;
   logic        out_valid;
   logic        out_ready;
   logic [35:0] out_wdat;
   logic [6:0]  out_sub;
   logic [3:0]  out_beat_idx;
   logic        out_last;
   logic [3:0]  fifo_level;
   logic        txn_done;
   logic        err_overflow;
   logic        err_length;
   logic        err_proto;
   logic        err_clr;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [35:0] w;
      logic [6:0]  s;
      logic [3:0]  i;
      logic        l;
   } beat_t;

   beat_t mq[$];
   int    m_cnt;
   bit    m_drop, m_done, m_ovf, m_len, m_proto;

   always #5 clk = ~clk;

   hero_write_rx dut (
      .clk(clk), .rst_n(rst_n), .hero_in(hero_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_wdat(out_wdat),
      .out_sub(out_sub), .out_beat_idx(out_beat_idx), .out_last(out_last),
      .fifo_level(fifo_level), .txn_done(txn_done),
      .err_overflow(err_overflow), .err_length(err_length), .err_proto(err_proto),
      .err_clr(err_clr)
   );

   function automatic logic [35:0] rand36();
      logic [35:0] v;
      v[31:0]  = $urandom;
      v[35:32] = 4'($urandom);
      return v;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_cnt = 0; m_drop = 0; m_done = 0; m_ovf = 0; m_len = 0; m_proto = 0;
   endtask

   // Drive one cycle of inputs, advance the reference model, then step past the clock edge
   task automatic tick(input logic [1:0] ct, input logic en, input logic [35:0] wd,
                       input logic [6:0] sb, input logic rdy, input logic clr);
      bit    full, qual, do_push, s_ovf, s_len, s_pro;
      beat_t b;
      hero_in = {ct, wd, sb, en}; out_ready = rdy; err_clr = clr;
      full = (mq.size() == DEPTH);
      qual = en && (ct == 2'd1 || ct == 2'd2);
      do_push = 0; s_ovf = 0; s_len = 0; s_pro = 0; m_done = 0;
      if (en && ct == 2'd3) s_pro = 1;
      else if (qual) begin
         if (m_drop) begin
            if (ct == 2'd2) m_drop = 0;
         end else if (full) begin
            s_ovf = 1; m_drop = (ct == 2'd1); m_cnt = 0;
         end else begin
            b.w = wd; b.s = sb; b.i = 4'(m_cnt);
            b.l = (ct == 2'd2) || (m_cnt == MAX_BEATS - 1);
            if (ct == 2'd1 && m_cnt == MAX_BEATS - 1) begin s_len = 1; m_drop = 1; end
            m_cnt = b.l ? 0 : m_cnt + 1;
            m_done = b.l;
            do_push = 1;
         end
      end
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (do_push) mq.push_back(b);
      m_ovf   = s_ovf | (m_ovf   & !clr);
      m_len   = s_len | (m_len   & !clr);
      m_proto = s_pro | (m_proto & !clr);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hero_in = '0; out_ready = 1'b0; err_clr = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      checks++; if ({txn_done, err_overflow, err_length, err_proto} !== 4'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=0000", {txn_done, err_overflow, err_length, err_proto}); end
      checks++; if ({out_wdat, out_sub, out_beat_idx, out_last} !== 48'd0) begin
         failures++; $display("FAIL reset_data got=%0h exp=0", {out_wdat, out_sub, out_beat_idx, out_last}); end
      rst_n = 1'b1;
      tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_single_done();
      tick(2'd2, 1'b1, 36'h123456789, 7'h15, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
      checks++; if ({out_beat_idx, out_last} !== 5'b0000_1) begin
         failures++; $display("FAIL single_idx_last got=%b exp=00001", {out_beat_idx, out_last}); end
      checks++; if ({out_wdat, out_sub} !== {36'h123456789, 7'h15}) begin
         failures++; $display("FAIL single_data got=%0h exp=%0h", {out_wdat, out_sub}, {36'h123456789, 7'h15}); end
      checks++; if (txn_done !== 1'b1) begin failures++; $display("FAIL single_txn_done got=%0b exp=1", txn_done); end
      tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
      checks++; if ({out_valid, txn_done} !== 2'b00) begin
         failures++; $display("FAIL single_after got=%b exp=00", {out_valid, txn_done}); end
      model_clear();
   endtask

   task automatic test_back_to_back();
      logic [35:0] wd;
      for (int k = 0; k < 3; k++) begin
         wd = rand36();
         tick((k == 2) ? 2'd2 : 2'd1, 1'b1, wd, 7'(k), 1'b1, 1'b0);
         checks++;
         if ({out_valid, out_beat_idx, out_last, out_wdat, fifo_level} !== {1'b1, 4'(k), (k == 2), wd, 4'd1}) begin
            failures++;
            $display("FAIL b2b_beat%0d got v=%0b idx=%0d last=%0b wdat=%0h lvl=%0d exp idx=%0d wdat=%0h",
                     k, out_valid, out_beat_idx, out_last, out_wdat, fifo_level, k, wd);
         end
      end
      tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0b exp=0", out_valid); end
   endtask

   task automatic test_overflow();
      beat_t h;
      for (int k = 0; k < 10; k++) tick(2'd1, 1'b1, rand36(), 7'($urandom), 1'b0, 1'b0);
      tick(2'd2, 1'b1, rand36(), 7'($urandom), 1'b0, 1'b0);
      checks++; if ({fifo_level, err_overflow} !== {4'd8, 1'b1}) begin
         failures++; $display("FAIL ovf_state got lvl=%0d ovf=%0b exp lvl=8 ovf=1", fifo_level, err_overflow); end
      for (int k = 0; k < 8; k++) begin
         h = (mq.size() > 0) ? mq[0] : '{default: '0};
         checks++;
         if ({out_valid, out_beat_idx, out_last, out_wdat, out_sub} !== {1'b1, 4'(k), 1'b0, h.w, h.s}) begin
            failures++;
            $display("FAIL ovf_drain%0d got v=%0b idx=%0d last=%0b wdat=%0h exp idx=%0d last=0 wdat=%0h",
                     k, out_valid, out_beat_idx, out_last, out_wdat, k, h.w);
         end
         tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0b exp=0", out_valid); end
      tick(2'd2, 1'b1, rand36(), 7'd0, 1'b1, 1'b0);
      checks++; if ({out_valid, out_beat_idx, out_last} !== 6'b1_0000_1) begin
         failures++; $display("FAIL ovf_next_txn got=%b exp=1000001", {out_valid, out_beat_idx, out_last}); end
      tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%0b exp=0", err_overflow); end
   endtask

   task automatic test_max_length();
      int dones = 0;
      for (int k = 0; k < 19; k++) begin
         tick((k == 18) ? 2'd2 : 2'd1, 1'b1, rand36(), 7'(k), 1'b1, 1'b0);
         dones += int'(txn_done);
         checks++;
         if (k < 16) begin
            if ({out_valid, out_beat_idx, out_last} !== {1'b1, 4'(k), (k == 15)}) begin
               failures++; $display("FAIL len_beat%0d got v=%0b idx=%0d last=%0b exp idx=%0d last=%0b",
                                    k, out_valid, out_beat_idx, out_last, k, (k == 15)); end
         end else if (out_valid !== 1'b0) begin
            failures++; $display("FAIL len_dropped%0d got=%0b exp=0", k, out_valid);
         end
      end
      tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
      dones += int'(txn_done);
      checks++; if (dones != 1) begin failures++; $display("FAIL len_txn_done got=%0d exp=1", dones); end
      checks++; if (err_length !== 1'b1) begin failures++; $display("FAIL len_err got=%0b exp=1", err_length); end
      tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (err_length !== 1'b0) begin failures++; $display("FAIL len_clr got=%0b exp=0", err_length); end
   endtask

   task automatic test_errors();
      for (int k = 0; k < 3; k++) tick(2'd1, 1'b0, rand36(), 7'd0, 1'b0, 1'b0);
      checks++; if ({out_valid, fifo_level} !== 5'd0) begin
         failures++; $display("FAIL clken_ignored got v=%0b lvl=%0d exp 0", out_valid, fifo_level); end
      tick(2'd3, 1'b1, rand36(), 7'd0, 1'b1, 1'b0);
      checks++; if ({err_proto, fifo_level} !== {1'b1, 4'd0}) begin
         failures++; $display("FAIL proto_set got err=%0b lvl=%0d exp err=1 lvl=0", err_proto, fifo_level); end
      tick(2'd3, 1'b1, rand36(), 7'd0, 1'b1, 1'b1);
      checks++; if (err_proto !== 1'b1) begin failures++; $display("FAIL proto_set_beats_clr got=%0b exp=1", err_proto); end
      tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (err_proto !== 1'b0) begin failures++; $display("FAIL proto_clr got=%0b exp=0", err_proto); end
      tick(2'd1, 1'b1, rand36(), 7'd0, 1'b1, 1'b0);
      tick(2'd3, 1'b1, rand36(), 7'd0, 1'b1, 1'b0);
      tick(2'd2, 1'b1, rand36(), 7'd0, 1'b1, 1'b1);
      checks++; if ({out_valid, out_beat_idx, out_last} !== 6'b1_0001_1) begin
         failures++; $display("FAIL proto_mid_txn got=%b exp=100011", {out_valid, out_beat_idx, out_last}); end
      tick(2'd0, 1'b0, '0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [1:0] ct;
      int         r;
      beat_t      h;
      for (int i = 0; i < 600; i++) begin
         r  = $urandom_range(0, 15);
         ct = (r == 0) ? 2'd3 : (r < 3) ? 2'd0 : (r < 12) ? 2'd1 : 2'd2;
         tick(ct, ($urandom_range(0, 7) != 0), rand36(), 7'($urandom),
              ($urandom_range(0, 3) < ((i < 300) ? 1 : 3)), ($urandom_range(0, 15) == 0));
         checks++;
         if (fifo_level !== 4'(mq.size())) begin
            failures++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, fifo_level, mq.size()); end
         checks++;
         if (mq.size() > 0) begin
            h = mq[0];
            if ({out_valid, out_wdat, out_sub, out_beat_idx, out_last} !== {1'b1, h.w, h.s, h.i, h.l}) begin
               failures++; $display("FAIL rnd_head cyc=%0d got v=%0b w=%0h s=%0h i=%0d l=%0b exp w=%0h s=%0h i=%0d l=%0b",
                                    i, out_valid, out_wdat, out_sub, out_beat_idx, out_last, h.w, h.s, h.i, h.l); end
         end else if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rnd_head cyc=%0d got v=%0b exp v=0", i, out_valid);
         end
         checks++;
         if ({txn_done, err_overflow, err_length, err_proto} !== {m_done, m_ovf, m_len, m_proto}) begin
            failures++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i,
                                 {txn_done, err_overflow, err_length, err_proto}, {m_done, m_ovf, m_len, m_proto}); end
      end
   endtask

   task automatic test_reset_mid_txn();
      logic [35:0] wd;
      rst_n = 1'b0; model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) tick(2'd1, 1'b1, rand36(), 7'd3, 1'b0, 1'b0);
      tick(2'd3, 1'b1, '0, '0, 1'b0, 1'b0);
      checks++; if ({fifo_level, err_proto} !== {4'd5, 1'b1}) begin
         failures++; $display("FAIL rstmid_pre got lvl=%0d proto=%0b exp lvl=5 proto=1", fifo_level, err_proto); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_wdat, out_sub, out_beat_idx, out_last, fifo_level, txn_done,
           err_overflow, err_length, err_proto} !== '0) begin
         failures++; $display("FAIL rstmid_async got v=%0b lvl=%0d wdat=%0h proto=%0b exp all 0",
                              out_valid, fifo_level, out_wdat, err_proto); end
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      wd = rand36();
      tick(2'd2, 1'b1, wd, 7'd9, 1'b1, 1'b0);
      checks++; if ({out_valid, out_beat_idx, out_last, out_wdat, fifo_level} !== {1'b1, 4'd0, 1'b1, wd, 4'd1}) begin
         failures++; $display("FAIL rstmid_single got v=%0b idx=%0d last=%0b wdat=%0h lvl=%0d exp idx=0 last=1 wdat=%0h",
                              out_valid, out_beat_idx, out_last, out_wdat, fifo_level, wd); end
   endtask

   initial begin
      test_reset();
      test_single_done();
      test_back_to_back();
      test_overflow();
      test_max_length();
      test_errors();
      test_random();
      test_reset_mid_txn();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
